// File: rtl/calc_pkg.sv
// Shared constants, scan-state type and helpers for the calculator keypad scanner.
package calc_pkg;

  localparam int ROW_N = 4;
  localparam int COL_N = 4;
  localparam int KEY_N = 16;

  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} scan_state_t;

  localparam logic [ROW_N-1:0] ROW0_PAT = 4'b1110;
  localparam logic [ROW_N-1:0] ROW1_PAT = 4'b1101;
  localparam logic [ROW_N-1:0] ROW2_PAT = 4'b1011;
  localparam logic [ROW_N-1:0] ROW3_PAT = 4'b0111;

  function automatic logic [ROW_N-1:0] row_pat(input scan_state_t s);
    case (s)
      ROW0:    row_pat = ROW0_PAT;
      ROW1:    row_pat = ROW1_PAT;
      ROW2:    row_pat = ROW2_PAT;
      default: row_pat = ROW3_PAT;
    endcase
  endfunction

  // Index of the lowest set bit; 0 when the map is empty.
  function automatic logic [3:0] lowest_set(input logic [KEY_N-1:0] m);
    lowest_set = '0;
    for (int i = KEY_N - 1; i >= 0; i--)
      if (m[i]) lowest_set = 4'(i);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, used as a clock enable.
module scan_tick_gen #(
  parameter int DIV = 250000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/calc_key_sample.sv
// 4x4 keypad scanner: one-cold row drive, per-row column capture, frame commit and new-press pulse.
// Optional KEY_DEBOUNCE_EN: commit a frame only when it matches the previous completed frame.
module calc_key_sample
  import calc_pkg::*;
#(
  parameter int NUM_FOR_200HZ = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COL_N-1:0] col,
  output logic [ROW_N-1:0] row,
  output logic [KEY_N-1:0] key_out,
  output logic             key_press,
  output logic [3:0]       key_code
);

  logic             tick;
  scan_state_t      state;
  scan_state_t      state_nxt;
  logic [KEY_N-1:0] shadow;
  logic             frame_vld;
  logic             commit;
  logic [KEY_N-1:0] new_bits;

  scan_tick_gen #(.DIV(NUM_FOR_200HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign state_nxt = scan_state_t'(state + 2'd1);

  // Row has been stable for a whole tick period when col is captured, so no synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ROW0;
      row       <= ROW0_PAT;
      shadow    <= '0;
      frame_vld <= 1'b0;
    end else begin
      frame_vld <= tick && (state == ROW3);
      if (tick) begin
        shadow[{state, 2'b00} +: COL_N] <= ~col;
        state                           <= state_nxt;
        row                             <= row_pat(state_nxt);
      end
    end
  end

`ifdef KEY_DEBOUNCE_EN
  logic [KEY_N-1:0] prev_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         prev_frame <= '0;
    else if (frame_vld) prev_frame <= shadow;
  end

  assign commit = frame_vld && (shadow == prev_frame);
`else
  assign commit = frame_vld;
`endif

  assign new_bits = shadow & ~key_out;

  // Only 0->1 transitions pulse; key_code holds between presses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out   <= '0;
      key_press <= 1'b0;
      key_code  <= '0;
    end else begin
      key_press <= 1'b0;
      if (commit) begin
        key_out   <= shadow;
        key_press <= |new_bits;
        if (|new_bits) key_code <= lowest_set(new_bits);
      end
    end
  end

endmodule

// File: tb/tb_calc_key_sample.sv
// Directed + randomized bench for calc_key_sample against a frame-level keypad model.
module tb_calc_key_sample;

  localparam int N     = 20;
  localparam int FRAME = 4 * N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_out;
  logic        key_press;
  logic [3:0]  key_code;

  logic        fixed_en = 1'b1;
  logic [3:0]  fixed_col = 4'hF;
  logic [15:0] pressed = '0;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // Keypad model: a pressed key shorts its column low when its row is driven low.
  function automatic logic [3:0] resp(input logic [3:0] r, input logic [15:0] p);
    logic [3:0] c;
    c = 4'hF;
    for (int i = 0; i < 4; i++)
      if (!r[i]) c = c & ~p[4*i +: 4];
    return c;
  endfunction

  function automatic logic [3:0] lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++)
      if (m[i]) return 4'(i);
    return 4'd0;
  endfunction

  assign col = fixed_en ? fixed_col : resp(row, pressed);

  calc_key_sample #(.NUM_FOR_200HZ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row       (row),
    .key_out   (key_out),
    .key_press (key_press),
    .key_code  (key_code)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (key_press) pulses++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Align to the start of a scan frame (row just switched to ROW0).
  task automatic frame_start();
    int g;
    g = 0;
    while (row == 4'b1110 && g < 400) begin @(negedge clk); g++; end
    while (row != 4'b1110 && g < 400) begin @(negedge clk); g++; end
    chk("frame_sync", 16'(g < 400), 16'd1);
  endtask

  initial begin
    logic [3:0]  pats [4];
    logic [15:0] prev_map, map, nw;
    logic [3:0]  exp_code;
    int          p0;
    pats[0] = 4'hE; pats[1] = 4'hD; pats[2] = 4'hB; pats[3] = 4'h7;

    // 1. reset state and row stepping
    #190;
    chk("rst_row", 16'(row), 16'hE);
    chk("rst_key_out", key_out, 16'h0);
    chk("rst_press", 16'(key_press), 16'h0);
    chk("rst_code", 16'(key_code), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      repeat (N) @(posedge clk);
      #1 chk($sformatf("row_step%0d", k), 16'(row), 16'(pats[k % 4]));
    end

    // 2. row-independent col=1011
    frame_start();
    p0 = pulses; fixed_col = 4'b1011;
    cycles(FRAME + 3);
`ifdef KEY_DEBOUNCE_EN
    chk("c1011_first_frame", key_out, 16'h0000);
`else
    chk("c1011_first_frame", key_out, 16'h4444);
`endif
    cycles(2 * FRAME);
    chk("c1011_key_out", key_out, 16'h4444);
    chk("c1011_pulses", 16'(pulses - p0), 16'd1);
    chk("c1011_code", 16'(key_code), 16'd2);

    // 3. release
    frame_start();
    p0 = pulses; fixed_col = 4'hF;
    cycles(FRAME + 3);
`ifndef KEY_DEBOUNCE_EN
    chk("release_first_frame", key_out, 16'h0000);
`endif
    cycles(2 * FRAME);
    chk("release_key_out", key_out, 16'h0000);
    chk("release_pulses", 16'(pulses - p0), 16'd0);
    chk("release_code_held", 16'(key_code), 16'd2);

    // 4. single key 5 with per-row model, held several frames
    frame_start();
    p0 = pulses; fixed_en = 1'b0; pressed = 16'h0020;
    cycles(5 * FRAME);
    chk("key5_key_out", key_out, 16'h0020);
    chk("key5_code", 16'(key_code), 16'd5);
    chk("key5_pulses", 16'(pulses - p0), 16'd1);

    // randomized key maps, changed on frame boundaries
    prev_map = 16'h0020; exp_code = 4'd5;
    for (int it = 0; it < 8; it++) begin
      map = 16'($urandom) & 16'($urandom);
      if (it == 3) map = prev_map;
      if (it == 5) map = '0;
      frame_start();
      p0 = pulses; pressed = map;
      cycles(3 * FRAME);
      nw = map & ~prev_map;
      if (nw != 0) exp_code = lowest(nw);
      chk($sformatf("rnd%0d_key_out", it), key_out, map);
      chk($sformatf("rnd%0d_pulses", it), 16'(pulses - p0), 16'(nw != 0));
      chk($sformatf("rnd%0d_code", it), 16'(key_code), 16'(exp_code));
      prev_map = map;
    end

    // one-frame glitch col=1110
    fixed_en = 1'b1; fixed_col = 4'hF;
    cycles(3 * FRAME);
    frame_start();
    p0 = pulses; fixed_col = 4'b1110;
    frame_start();
    fixed_col = 4'hF;
    cycles(3 * FRAME);
    chk("glitch_key_out", key_out, 16'h0000);
`ifdef KEY_DEBOUNCE_EN
    chk("glitch_pulses", 16'(pulses - p0), 16'd0);
`else
    chk("glitch_pulses", 16'(pulses - p0), 16'd1);
`endif

    // two-frame hold of col=1110
    frame_start();
    p0 = pulses; fixed_col = 4'b1110;
    cycles(FRAME + 3);
`ifdef KEY_DEBOUNCE_EN
    chk("hold_first_frame", key_out, 16'h0000);
`else
    chk("hold_first_frame", key_out, 16'h1111);
`endif
    cycles(FRAME);
    chk("hold_second_frame", key_out, 16'h1111);
    chk("hold_pulses", 16'(pulses - p0), 16'd1);
    chk("hold_code", 16'(key_code), 16'd0);

    // 5. reset mid-frame with col=0111
    fixed_col = 4'b0111;
    cycles(3 * FRAME);
    chk("pre_reset_key_out", key_out, 16'h8888);
    frame_start();
    cycles(30);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_key_out", key_out, 16'h0000);
    chk("midrst_row", 16'(row), 16'hE);
    chk("midrst_code", 16'(key_code), 16'h0);
    cycles(3);
    p0 = pulses; rst_n = 1'b1;
    cycles(FRAME + 3);
`ifdef KEY_DEBOUNCE_EN
    chk("postrst_first_frame", key_out, 16'h0000);
`else
    chk("postrst_first_frame", key_out, 16'h8888);
`endif
    cycles(FRAME);
    chk("postrst_key_out", key_out, 16'h8888);
    chk("postrst_pulses", 16'(pulses - p0), 16'd1);
    chk("postrst_code", 16'(key_code), 16'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
